// File: rtl/probe_sched_pkg.sv
// Shared definitions for the probe frame scheduler.
//   sched_state_e : scheduler FSM states
//   DefDw         : default pixel width
//   DefCoordW     : default x/y counter width
//   pack_xy()     : packs 12-bit y/x coordinates into the 24-bit probe_xy word
package probe_sched_pkg;

    localparam int unsigned DefDw     = 24;
    localparam int unsigned DefCoordW = 12;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StSync = 2'd1,
        StRun  = 2'd2
    } sched_state_e;

    function automatic logic [23:0] pack_xy(input logic [11:0] y, input logic [11:0] x);
        return {y, x};
    endfunction

endpackage

// File: rtl/probe_rr_pick.sv
// Combinational round-robin finder: returns the lowest enabled index strictly above
// cur, wrapping to the lowest enabled index overall. With cur = NUM_SRC-1 it yields
// the lowest enabled index. If only cur is enabled, cur itself is returned.
//   mask  : enabled sources
//   cur   : current index
//   next  : next enabled index (0 when none)
//   valid : at least one source is enabled
module probe_rr_pick #(
    parameter int unsigned NUM_SRC = 4,
    parameter int unsigned SW      = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic [NUM_SRC-1:0] mask,
    input  logic [SW-1:0]      cur,
    output logic [SW-1:0]      next,
    output logic               valid
);

    int unsigned idx;

    always_comb begin
        next  = '0;
        valid = 1'b0;
        idx   = 0;
        // Scan cur+1 .. cur+NUM_SRC modulo NUM_SRC; first hit wins.
        for (int unsigned i = 1; i <= NUM_SRC; i++) begin
            idx = 32'(cur) + i;
            if (idx >= NUM_SRC) begin
                idx = idx - NUM_SRC;
            end
            if (!valid && mask[idx[SW-1:0]]) begin
                next  = idx[SW-1:0];
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/probe_frame_sched.sv
// Frame-synchronous scheduler sharing the debug probe lanes between pixel sources.
// Rotates round-robin over enabled sources on frame boundaries, gates pixels to a
// programmable window, tags samples with {y, x} and pulses a trigger qualifier on
// the first in-window pixel of each frame. All outputs are registered.
//   clk, rst_n                 : pixel clock, async active-low reset
//   vsync, hsync, de, src_data : video timing and packed source pixels
//   cfg_*                      : enable, source mask, dwell, inclusive window
//   probe_vs/hs/de/pix/xy/trig : probe lanes (zero outside RUN)
//   cur_src, busy              : routed source, high while running
module probe_frame_sched
    import probe_sched_pkg::*;
#(
    parameter int unsigned NUM_SRC = 4,
    parameter int unsigned DW      = DefDw,
    parameter int unsigned COORD_W = DefCoordW,
    localparam int unsigned SW     = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   vsync,
    input  logic                   hsync,
    input  logic                   de,
    input  logic [NUM_SRC*DW-1:0]  src_data,
    input  logic                   cfg_en,
    input  logic [NUM_SRC-1:0]     cfg_src_mask,
    input  logic [7:0]             cfg_frames_per_src,
    input  logic [COORD_W-1:0]     cfg_win_x0,
    input  logic [COORD_W-1:0]     cfg_win_x1,
    input  logic [COORD_W-1:0]     cfg_win_y0,
    input  logic [COORD_W-1:0]     cfg_win_y1,
    output logic                   probe_vs,
    output logic                   probe_hs,
    output logic                   probe_de,
    output logic [DW-1:0]          probe_pix,
    output logic [23:0]            probe_xy,
    output logic                   probe_trig,
    output logic [SW-1:0]          cur_src,
    output logic                   busy
);

    localparam logic [COORD_W-1:0] CoordMax = '1;
    localparam logic [SW-1:0]      LastIdx  = SW'(NUM_SRC - 1);

    sched_state_e state_q, state_d;

    logic               vs_q, hs_q, de_q;
    logic               vs_rise, hs_rise, de_fall;
    logic [COORD_W-1:0] x_q, x_d, y_q, y_d, x_cur, y_cur;
    logic               in_win;

    logic [SW-1:0]      cur_src_q, cur_src_d;
    logic [SW-1:0]      pick_cur, pick_next;
    logic               pick_valid;
    logic               sched_ok;
    logic [7:0]         frame_cnt_q, frame_cnt_d, frame_cnt_inc, dwell;

    logic               trig_done_q, trig_done_d, trig_done_cur;
    logic               active;
    logic [DW-1:0]      src_pix;

    logic               probe_vs_d, probe_hs_d, probe_de_d, probe_trig_d;
    logic [DW-1:0]      probe_pix_d;
    logic [23:0]        probe_xy_d;

    assign vs_rise = vsync & ~vs_q;
    assign hs_rise = hsync & ~hs_q;
    assign de_fall = ~de & de_q;

    // Pixel coordinates: the current pixel sees the cleared value in the edge cycle.
    always_comb begin
        x_cur = hs_rise ? '0 : x_q;
        y_cur = vs_rise ? '0 : y_q;
        x_d   = x_cur;
        if (de && (x_cur != CoordMax)) begin
            x_d = x_cur + 1'b1;
        end
        y_d = y_cur;
        if (!vs_rise && de_fall && (y_q != CoordMax)) begin
            y_d = y_q + 1'b1;
        end
    end

    assign in_win = de
                  & (x_cur >= cfg_win_x0) & (x_cur <= cfg_win_x1)
                  & (y_cur >= cfg_win_y0) & (y_cur <= cfg_win_y1);

    // Outside RUN the search starts at the top index so it wraps to the lowest enabled.
    assign pick_cur = (state_q == StRun) ? cur_src_q : LastIdx;

    probe_rr_pick #(
        .NUM_SRC (NUM_SRC),
        .SW      (SW)
    ) u_pick (
        .mask  (cfg_src_mask),
        .cur   (pick_cur),
        .next  (pick_next),
        .valid (pick_valid)
    );

    assign sched_ok      = cfg_en & pick_valid;
    assign dwell         = (cfg_frames_per_src == 8'd0) ? 8'd1 : cfg_frames_per_src;
    assign frame_cnt_inc = frame_cnt_q + 8'd1;

    always_comb begin
        state_d     = state_q;
        cur_src_d   = cur_src_q;
        frame_cnt_d = frame_cnt_q;
        unique case (state_q)
            StIdle: begin
                frame_cnt_d = '0;
                if (sched_ok) begin
                    state_d = StSync;
                end
            end
            StSync: begin
                if (!sched_ok) begin
                    state_d = StIdle;
                end else if (vs_rise) begin
                    state_d     = StRun;
                    cur_src_d   = pick_next;
                    frame_cnt_d = '0;
                end
            end
            StRun: begin
                if (!sched_ok) begin
                    state_d     = StIdle;
                    frame_cnt_d = '0;
                end else if (vs_rise) begin
                    // A source dropped from the mask is left at the boundary regardless of dwell.
                    if ((frame_cnt_inc >= dwell) || !cfg_src_mask[cur_src_q]) begin
                        cur_src_d   = pick_next;
                        frame_cnt_d = '0;
                    end else begin
                        frame_cnt_d = frame_cnt_inc;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Output stage looks at the next state and next source so that a source switch
    // at vsync already applies to the sample registered in that cycle.
    assign active        = (state_d == StRun);
    assign src_pix       = src_data[cur_src_d*DW +: DW];
    assign trig_done_cur = vs_rise ? 1'b0 : trig_done_q;
    assign trig_done_d   = active & (trig_done_cur | in_win);

    always_comb begin
        probe_vs_d   = 1'b0;
        probe_hs_d   = 1'b0;
        probe_de_d   = 1'b0;
        probe_pix_d  = '0;
        probe_xy_d   = '0;
        probe_trig_d = 1'b0;
        if (active) begin
            probe_vs_d   = vsync;
            probe_hs_d   = hsync;
            probe_de_d   = in_win;
            probe_pix_d  = in_win ? src_pix : '0;
            probe_xy_d   = pack_xy(12'(y_cur), 12'(x_cur));
            probe_trig_d = in_win & ~trig_done_cur;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            vs_q        <= 1'b0;
            hs_q        <= 1'b0;
            de_q        <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            cur_src_q   <= '0;
            frame_cnt_q <= '0;
            trig_done_q <= 1'b0;
            probe_vs    <= 1'b0;
            probe_hs    <= 1'b0;
            probe_de    <= 1'b0;
            probe_pix   <= '0;
            probe_xy    <= '0;
            probe_trig  <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state_q     <= state_d;
            vs_q        <= vsync;
            hs_q        <= hsync;
            de_q        <= de;
            x_q         <= x_d;
            y_q         <= y_d;
            cur_src_q   <= cur_src_d;
            frame_cnt_q <= frame_cnt_d;
            trig_done_q <= trig_done_d;
            probe_vs    <= probe_vs_d;
            probe_hs    <= probe_hs_d;
            probe_de    <= probe_de_d;
            probe_pix   <= probe_pix_d;
            probe_xy    <= probe_xy_d;
            probe_trig  <= probe_trig_d;
            busy        <= active;
        end
    end

    assign cur_src = cur_src_q;

endmodule

// File: tb/tb_probe_frame_sched.sv
// Directed bench for probe_frame_sched: a frame-level behavioural model predicts every
// output each cycle, and per-test literal expectations pin the model's behaviour.
module tb_probe_frame_sched;

    localparam int NS = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          vsync = 1'b0, hsync = 1'b0, de = 1'b0;
    logic [NS*24-1:0] src_data = '0;
    logic          cfg_en = 1'b0;
    logic [NS-1:0] cfg_src_mask = '0;
    logic [7:0]    cfg_frames_per_src = 8'd1;
    logic [11:0]   cfg_win_x0 = 12'd10, cfg_win_x1 = 12'd12;
    logic [11:0]   cfg_win_y0 = 12'd2, cfg_win_y1 = 12'd2;

    logic          probe_vs, probe_hs, probe_de, probe_trig, busy;
    logic [23:0]   probe_pix, probe_xy;
    logic [1:0]    cur_src;

    probe_frame_sched #(
        .NUM_SRC (NS),
        .DW      (24),
        .COORD_W (12)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .vsync              (vsync),
        .hsync              (hsync),
        .de                 (de),
        .src_data           (src_data),
        .cfg_en             (cfg_en),
        .cfg_src_mask       (cfg_src_mask),
        .cfg_frames_per_src (cfg_frames_per_src),
        .cfg_win_x0         (cfg_win_x0),
        .cfg_win_x1         (cfg_win_x1),
        .cfg_win_y0         (cfg_win_y0),
        .cfg_win_y1         (cfg_win_y1),
        .probe_vs           (probe_vs),
        .probe_hs           (probe_hs),
        .probe_de           (probe_de),
        .probe_pix          (probe_pix),
        .probe_xy           (probe_xy),
        .probe_trig         (probe_trig),
        .cur_src            (cur_src),
        .busy               (busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // phase: 0 disabled, 1 waiting for a frame start, 2 running
    int  m_phase = 0, m_src = 0, m_frames = 0, m_x = 0, m_y = 0;
    bit  m_vs = 0, m_hs = 0, m_de = 0, m_seen = 0;

    bit          cmp_vs = 0, cmp_hs = 0, cmp_de = 0, cmp_trig = 0, cmp_busy = 0;
    logic [23:0] cmp_pix = '0, cmp_xy = '0;
    int          cmp_src = 0;

    function automatic int first_enabled(input logic [NS-1:0] m);
        for (int i = 0; i < NS; i++) if (m[i]) return i;
        return 0;
    endfunction

    function automatic int next_enabled(input logic [NS-1:0] m, input int s);
        int list[$];
        for (int i = 0; i < NS; i++) if (m[i]) list.push_back(i);
        foreach (list[k]) if (list[k] > s) return list[k];
        return list[0];
    endfunction

    task automatic step();
        bit vr, hr, df, ok, win;
        int px, py, dw;
        bit n_vs, n_hs, n_de, n_trig, n_busy;
        logic [23:0] n_pix, n_xy;
        vr = vsync && !m_vs;
        hr = hsync && !m_hs;
        df = !de && m_de;
        px = hr ? 0 : m_x;
        py = vr ? 0 : m_y;
        ok = cfg_en && (cfg_src_mask != '0);
        dw = (cfg_frames_per_src == 8'd0) ? 1 : int'(cfg_frames_per_src);
        if (!ok) m_phase = 0;
        else if (m_phase == 0) m_phase = 1;
        else if (m_phase == 1) begin
            if (vr) begin
                m_phase  = 2;
                m_src    = first_enabled(cfg_src_mask);
                m_frames = 0;
            end
        end else if (vr) begin
            m_frames++;
            if (m_frames >= dw || !cfg_src_mask[m_src]) begin
                m_src    = next_enabled(cfg_src_mask, m_src);
                m_frames = 0;
            end
        end
        win = de && px >= int'(cfg_win_x0) && px <= int'(cfg_win_x1)
                 && py >= int'(cfg_win_y0) && py <= int'(cfg_win_y1);
        if (vr) m_seen = 0;
        n_vs = 0; n_hs = 0; n_de = 0; n_trig = 0; n_busy = 0; n_pix = '0; n_xy = '0;
        if (m_phase == 2) begin
            n_vs   = vsync;
            n_hs   = hsync;
            n_de   = win;
            n_pix  = win ? src_data[m_src*24 +: 24] : 24'd0;
            n_xy   = 24'(py * 4096 + px);
            n_trig = win && !m_seen;
            n_busy = 1;
            if (win) m_seen = 1;
        end else begin
            m_seen = 0;
        end
        m_x = (px + (de ? 1 : 0) > 4095) ? 4095 : px + (de ? 1 : 0);
        if (vr) m_y = 0;
        else if (df && m_y < 4095) m_y = m_y + 1;
        m_vs = vsync; m_hs = hsync; m_de = de;
        @(posedge clk);
        cmp_vs = n_vs; cmp_hs = n_hs; cmp_de = n_de; cmp_trig = n_trig; cmp_busy = n_busy;
        cmp_pix = n_pix; cmp_xy = n_xy; cmp_src = m_src;
        #1;
    endtask

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        chk("probe_vs", 32'(probe_vs), 32'(cmp_vs));
        chk("probe_hs", 32'(probe_hs), 32'(cmp_hs));
        chk("probe_de", 32'(probe_de), 32'(cmp_de));
        chk("probe_pix", 32'(probe_pix), 32'(cmp_pix));
        chk("probe_xy", 32'(probe_xy), 32'(cmp_xy));
        chk("probe_trig", 32'(probe_trig), 32'(cmp_trig));
        chk("busy", 32'(busy), 32'(cmp_busy));
        chk("cur_src", 32'(cur_src), 32'(cmp_src));
    end

    // Collectors for the literal per-test checks.
    logic [23:0] de_log[$];
    logic [23:0] trig_log[$];
    int          src_log[$];
    bit          busy_log[$];

    always @(negedge clk) begin
        if (probe_de)   de_log.push_back(probe_xy);
        if (probe_trig) trig_log.push_back(probe_xy);
    end

    task automatic clear_logs();
        de_log.delete(); trig_log.delete(); src_log.delete(); busy_log.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        m_phase = 0; m_src = 0; m_frames = 0; m_x = 0; m_y = 0;
        m_vs = 0; m_hs = 0; m_de = 0; m_seen = 0;
        cmp_vs = 0; cmp_hs = 0; cmp_de = 0; cmp_trig = 0; cmp_busy = 0;
        cmp_pix = '0; cmp_xy = '0; cmp_src = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_cur_src", 32'(cur_src), 32'd0);
        chk("reset_xy", 32'(probe_xy), 32'd0);
        rst_n = 1'b1;
    endtask

    task automatic frame_head();
        vsync = 1'b1;
        step();
        src_log.push_back(int'(cur_src));
        busy_log.push_back(busy);
        step();
        vsync = 1'b0;
        step();
        step();
    endtask

    task automatic line(input int w);
        hsync = 1'b1; step();
        hsync = 1'b0; step(); step();
        for (int p = 0; p < w; p++) begin
            de = 1'b1;
            for (int s = 0; s < NS; s++) src_data[s*24 +: 24] = 24'($urandom);
            step();
        end
        de = 1'b0; step(); step();
    endtask

    task automatic frame(input int w, input int h);
        frame_head();
        for (int l = 0; l < h; l++) line(w);
    endtask

    task automatic restart();
        cfg_en = 1'b0; step();
        cfg_en = 1'b1; step();
    endtask

    task automatic chk_srcs(input string name, input int exp[]);
        chk({name, "_len"}, 32'(src_log.size()), 32'(exp.size()));
        foreach (exp[i]) if (i < src_log.size()) chk(name, 32'(src_log[i]), 32'(exp[i]));
    endtask

    initial begin
        int e1[] = '{1, 3, 1, 3, 1};
        int e3[] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 0};
        int e4[] = '{0, 0, 0, 1, 2};
        int e6[] = '{1, 3, 1, 3};

        // 1: reset release already enabled, alternating sources 1 and 3
        cfg_en = 1'b1; cfg_src_mask = 4'b1010; cfg_frames_per_src = 8'd1;
        do_reset();
        step(); step();
        chk("t1_busy_before_vsync", 32'(busy), 32'd0);
        clear_logs();
        repeat (5) frame(16, 4);
        chk_srcs("t1_src_seq", e1);
        foreach (busy_log[i]) chk("t1_busy_at_vsync", 32'(busy_log[i]), 32'd1);

        // 2: window 10..12 on line 2
        clear_logs();
        repeat (2) frame(16, 4);
        chk("t2_de_count", 32'(de_log.size()), 32'd6);
        if (de_log.size() >= 3) begin
            chk("t2_xy0", 32'(de_log[0]), 32'h00200A);
            chk("t2_xy1", 32'(de_log[1]), 32'h00200B);
            chk("t2_xy2", 32'(de_log[2]), 32'h00200C);
        end
        chk("t2_trig_count", 32'(trig_log.size()), 32'd2);
        if (trig_log.size() > 0) chk("t2_trig_xy", 32'(trig_log[0]), 32'h00200A);

        // 3: dwell 3 over sources 0..2
        cfg_src_mask = 4'b0111; cfg_frames_per_src = 8'd3;
        restart();
        clear_logs();
        repeat (10) frame(4, 2);
        chk_srcs("t3_src_seq", e3);

        // 4: drop source 1 mid-frame while it is current
        restart();
        clear_logs();
        repeat (3) frame(4, 2);
        frame_head();
        line(4);
        cfg_src_mask = 4'b0101;
        line(4);
        chk("t4_hold_src", 32'(cur_src), 32'd1);
        frame(4, 2);
        chk_srcs("t4_src_seq", e4);

        // 5: disable mid-line, re-enable, silent until next vsync
        cfg_win_x0 = 12'd10; cfg_win_x1 = 12'd12;
        frame_head();
        line(16);
        hsync = 1'b1; step();
        hsync = 1'b0; step(); step();
        for (int p = 0; p < 5; p++) begin de = 1'b1; step(); end
        chk("t5_xy_before", 32'(probe_xy), 32'h001004);
        cfg_en = 1'b0; step();
        chk("t5_busy_off", 32'(busy), 32'd0);
        chk("t5_xy_off", 32'(probe_xy), 32'd0);
        chk("t5_hs_off", 32'(probe_hs), 32'd0);
        cfg_en = 1'b1;
        for (int p = 0; p < 11; p++) step();
        de = 1'b0; step(); step();
        clear_logs();
        line(16); line(16);
        chk("t5_silent_de", 32'(de_log.size()), 32'd0);
        chk("t5_silent_busy", 32'(busy), 32'd0);
        frame(16, 4);
        chk("t5_resume_src", 32'(src_log[0]), 32'd0);
        chk("t5_resume_busy", 32'(busy_log[0]), 32'd1);

        // 6: dwell 0 acts as 1, empty window (x0 > x1)
        cfg_src_mask = 4'b1010; cfg_frames_per_src = 8'd0;
        cfg_win_x0 = 12'd12; cfg_win_x1 = 12'd10;
        restart();
        clear_logs();
        repeat (4) frame(16, 4);
        chk_srcs("t6_src_seq", e6);
        chk("t6_de_count", 32'(de_log.size()), 32'd0);
        chk("t6_trig_count", 32'(trig_log.size()), 32'd0);

        step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
